octave_decimator: RTL and testbench

//  Sits between two octave stages: consumes an octave's next_octave_dout/valid/blanking stream
//  (gauss3 image, `width` pixels per line) and produces the half-resolution stream feeding the

---
 rtl/octave_decimator.sv | 107 ++++++++++
 tb/tb_octave_decimator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/octave_decimator.sv
// 2:1 spatial decimator between octave stages: subsamples or 2x2 box-averages the
// gauss3 stream to half resolution, forwarding blanking samples so downstream windows flush.
module octave_decimator #(
  parameter int width   = 420,
  parameter int average = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       validin,
  input  logic       blanking_in,
  output logic [7:0] dout,
  output logic       validout,
  output logic       blanking_out
);

  localparam int HALF = width / 2;
  localparam int CW   = (width > 2) ? $clog2(width) : 1;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  if (((width % 2) != 0) || (width < 2)) begin : g_width_check
    $error("octave_decimator: width must be even and at least 2");
  end

  // Rounded mean of two 9-bit pair sums; the 10-bit sum of four 8-bit pixels
  // plus 2 never exceeds 1022, so the quotient always fits in 8 bits.
  function automatic logic [7:0] round_mean4(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {1'b0, a} + {1'b0, b} + 10'd2;
    return s[9:2];
  endfunction

  logic [CW-1:0] r_col;
  logic          r_row_odd;
  logic [7:0]    r_pix_hold;
  logic [8:0]    r_linebuf [HALF];
  logic [7:0]    r_dout_p1;
  logic          r_vld_p1;
  logic          r_blank_p1;

  logic          w_img;
  logic          w_blank;
  logic          w_last;
  logic [AW-1:0] w_addr;
  logic [8:0]    w_pair;
  logic [8:0]    w_rd;

  assign w_img   = validin & ~blanking_in;
  assign w_blank = validin & blanking_in;
  assign w_last  = (r_col == CW'(width - 1));
  assign w_addr  = AW'(r_col >> 1);
  assign w_pair  = {1'b0, r_pix_hold} + {1'b0, din};
  assign w_rd    = r_linebuf[w_addr];

  // Stage p0 -> p1: column/row tracking and output register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col      <= '0;
      r_row_odd  <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_blank_p1 <= 1'b1;
      r_dout_p1  <= '0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (w_blank) begin
        r_col      <= '0;
        r_row_odd  <= 1'b0;
        r_vld_p1   <= 1'b1;
        r_blank_p1 <= 1'b1;
        r_dout_p1  <= din;
      end else if (w_img) begin
        if (w_last) begin
          r_col     <= '0;
          r_row_odd <= ~r_row_odd;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (average == 0) begin
          if (!r_row_odd && !r_col[0]) begin
            r_vld_p1   <= 1'b1;
            r_blank_p1 <= 1'b0;
            r_dout_p1  <= din;
          end
        end else if (r_row_odd && r_col[0]) begin
          r_vld_p1   <= 1'b1;
          r_blank_p1 <= 1'b0;
          r_dout_p1  <= round_mean4(w_rd, w_pair);
        end
      end
    end
  end

  // Pair accumulation and even-row line storage; odd rows only read, so no hazard
  always_ff @(posedge clock) begin
    if (w_img && !r_col[0]) begin
      r_pix_hold <= din;
    end
    if ((average != 0) && w_img && r_col[0] && !r_row_odd) begin
      r_linebuf[w_addr] <= w_pair;
    end
  end

  assign dout         = r_dout_p1;
  assign validout     = r_vld_p1;
  assign blanking_out = r_blank_p1;

endmodule

// File: tb/tb_octave_decimator.sv
// Bench for octave_decimator: three instances (subsample w=8, average w=8, subsample w=420)
// share one input stream; a behavioural model feeds per-instance expected-output queues.
module tb_octave_decimator;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       validin;
  logic       blanking_in;

  logic [7:0] dout0, dout1, dout2;
  logic       vo0, vo1, vo2;
  logic       bo0, bo1, bo2;

  always #5 clock = ~clock;

  octave_decimator #(.width(8), .average(0)) u_sub8 (
    .clock(clock), .reset(reset), .din(din), .validin(validin), .blanking_in(blanking_in),
    .dout(dout0), .validout(vo0), .blanking_out(bo0));

  octave_decimator #(.width(8), .average(1)) u_avg8 (
    .clock(clock), .reset(reset), .din(din), .validin(validin), .blanking_in(blanking_in),
    .dout(dout1), .validout(vo1), .blanking_out(bo1));

  octave_decimator #(.width(420), .average(0)) u_sub420 (
    .clock(clock), .reset(reset), .din(din), .validin(validin), .blanking_in(blanking_in),
    .dout(dout2), .validout(vo2), .blanking_out(bo2));

  int n_vec  = 0;
  int n_fail = 0;

  int mw   [3] = '{8, 8, 420};
  int mavg [3] = '{0, 1, 0};
  int m_col  [3];
  int m_row  [3];
  int m_hold [3];
  int m_buf  [3][210];

  logic [8:0] expq [3][$];
  int         log0 [$];
  int         log1 [$];
  int         cnt2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_cycle(input logic [7:0] d, input logic v, input logic b, input logic r);
    int pair;
    for (int id = 0; id < 3; id++) begin
      if (r) begin
        m_col[id] = 0;
        m_row[id] = 0;
        expq[id].delete();
      end else if (v && b) begin
        expq[id].push_back({1'b1, d});
        m_col[id] = 0;
        m_row[id] = 0;
      end else if (v) begin
        if (mavg[id] == 0) begin
          if (m_row[id] == 0 && (m_col[id] % 2) == 0) expq[id].push_back({1'b0, d});
        end else if ((m_col[id] % 2) == 0) begin
          m_hold[id] = d;
        end else begin
          pair = m_hold[id] + int'(d);
          if (m_row[id] == 0) m_buf[id][m_col[id] / 2] = pair;
          else expq[id].push_back({1'b0, 8'((m_buf[id][m_col[id] / 2] + pair + 2) / 4)});
        end
        if (m_col[id] == mw[id] - 1) begin
          m_col[id] = 0;
          m_row[id] = 1 - m_row[id];
        end else begin
          m_col[id] = m_col[id] + 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic       vo [3];
    logic [8:0] ob [3];
    logic       exp_v;
    logic [8:0] e;
    vo[0] = vo0; vo[1] = vo1; vo[2] = vo2;
    ob[0] = {bo0, dout0}; ob[1] = {bo1, dout1}; ob[2] = {bo2, dout2};
    for (int id = 0; id < 3; id++) begin
      exp_v = (expq[id].size() != 0);
      chk($sformatf("validout[%0d]", id), 32'(vo[id]), 32'(exp_v));
      if (exp_v) begin
        e = expq[id].pop_front();
        if (vo[id] === 1'b1) chk($sformatf("blank_dout[%0d]", id), 32'(ob[id]), 32'(e));
      end
      if (vo[id] === 1'b1 && ob[id][8] === 1'b0) begin
        if (id == 0) log0.push_back(int'(ob[id][7:0]));
        if (id == 1) log1.push_back(int'(ob[id][7:0]));
        if (id == 2) cnt2++;
      end
    end
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic b);
    din         = d;
    validin     = v;
    blanking_in = b;
    @(posedge clock);
    model_cycle(d, v, b, reset);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic check_log(input string tag, input int got [$], input int want [$]);
    chk({tag, "_count"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(want[i]));
  endtask

  initial begin
    reset = 1'b1; din = '0; validin = 1'b0; blanking_in = 1'b0; cnt2 = 0;
    @(negedge clock);
    step(8'd9, 1'b1, 1'b0);
    step(8'd0, 1'b0, 1'b0);
    chk("rst_vld0", 32'(vo0), 32'd0);
    chk("rst_blank0", 32'(bo0), 32'd1);
    chk("rst_dout0", 32'(dout0), 32'd0);
    chk("rst_blank1", 32'(bo1), 32'd1);
    chk("rst_blank2", 32'(bo2), 32'd1);
    reset = 1'b0;

    // Case 1: subsample, two lines, din = col + 16*row
    log0.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) step(8'(c + 16 * r), 1'b1, 1'b0);
    check_log("c1_sub", log0, '{0, 2, 4, 6});

    // Case 2: box average over two known rows
    step(8'd0, 1'b1, 1'b1);
    log1.delete();
    for (int c = 0; c < 8; c++) step(8'(10 + 10 * c), 1'b1, 1'b0);
    chk("c2_row0_silent", 32'(log1.size()), 32'd0);
    for (int c = 0; c < 8; c++) step(8'(12 + 10 * c), 1'b1, 1'b0);
    check_log("c2_avg", log1, '{16, 36, 56, 76});

    // Case 3: saturated block and rounding block
    step(8'd0, 1'b1, 1'b1);
    log1.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) step((c % 4) < 2 ? 8'd255 : 8'(c % 2), 1'b1, 1'b0);
    check_log("c3_round", log1, '{255, 1, 255, 1});

    // Case 4: blanking inserted at col 3 of row 0
    step(8'd0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) step(8'(c + 40), 1'b1, 1'b0);
    step(8'hA5, 1'b1, 1'b1);
    chk("c4_blank_vld", 32'(vo0), 32'd1);
    chk("c4_blank_flag", 32'(bo0), 32'd1);
    chk("c4_blank_dout", 32'(dout0), 32'hA5);
    step(8'd77, 1'b1, 1'b0);
    chk("c4_restart_vld", 32'(vo0), 32'd1);
    chk("c4_restart_dout", 32'(dout0), 32'd77);

    // Case 5: validin toggling, then a full-width frame
    step(8'd0, 1'b1, 1'b1);
    log0.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) begin
        step(8'(c + 16 * r), 1'b1, 1'b0);
        step(8'hEE, 1'b0, 1'b0);
      end
    check_log("c5_toggle", log0, '{0, 2, 4, 6});
    step(8'd0, 1'b1, 1'b1);
    cnt2 = 0;
    for (int c = 0; c < 420; c++) step(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    chk("c5_w420_row0", 32'(cnt2), 32'd210);
    for (int c = 0; c < 420; c++) step(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    chk("c5_w420_row1", 32'(cnt2), 32'd210);

    // Case 6: reset mid row 1, then a fresh row 0
    step(8'd0, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) step(8'(c + 50), 1'b1, 1'b0);
    reset = 1'b1;
    step(8'd33, 1'b1, 1'b0);
    chk("c6_rst_vld", 32'(vo0), 32'd0);
    chk("c6_rst_blank", 32'(bo0), 32'd1);
    chk("c6_rst_dout", 32'(dout0), 32'd0);
    reset = 1'b0;
    log0.delete();
    for (int c = 0; c < 8; c++) step(8'(100 + c), 1'b1, 1'b0);
    check_log("c6_after_rst", log0, '{100, 102, 104, 106});

    step(8'd0, 1'b0, 1'b0);
    for (int id = 0; id < 3; id++) chk($sformatf("drain[%0d]", id), 32'(expq[id].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
